// File: rtl/irq_ctrl_pkg.sv
// rtl/irq_ctrl_pkg.sv - shared types and helpers for the prioritised interrupt controller
package irq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    IRQ,
    EXC,
    IRQ_EXC
  } irq_state_t;

  localparam logic [31:0] CAUSE_BASE_DEFAULT = 32'h8000_0010;

  function automatic logic [31:0] idx_to_cause(input logic [31:0] base, input logic [31:0] idx);
    return base + idx;
  endfunction

endpackage

// File: rtl/irq_prio_arbiter.sv
// rtl/irq_prio_arbiter.sv - combinational fixed/rotating priority pick over eligible lines
module irq_prio_arbiter #(
  parameter int IRQ_NUM = 16,
  parameter int IW      = (IRQ_NUM > 1) ? $clog2(IRQ_NUM) : 1
) (
  input  logic [IRQ_NUM-1:0] eligible,
  input  logic [IW-1:0]      rr_ptr,
  input  logic               rr_en,
  output logic               valid,
  output logic [IW-1:0]      winner,
  output logic [IRQ_NUM-1:0] grant
);

  logic [IW-1:0] base;
  logic [IW-1:0] cand_idx;
  int            cand;

  always_comb begin
    // Fixed priority is the rotating search with the pointer parked on the top line.
    base     = rr_en ? rr_ptr : IW'(IRQ_NUM - 1);
    valid    = 1'b0;
    winner   = '0;
    grant    = '0;
    cand     = 0;
    cand_idx = '0;
    // Walk from the farthest candidate back to the nearest so the nearest one wins.
    for (int i = IRQ_NUM; i >= 1; i--) begin
      cand     = (int'(base) + i) % IRQ_NUM;
      cand_idx = IW'(cand);
      if (eligible[cand_idx]) begin
        valid  = 1'b1;
        winner = cand_idx;
      end
    end
    if (valid) begin
      grant[winner] = 1'b1;
    end
  end

endmodule

// File: rtl/interrupt_controller_prio.sv
// rtl/interrupt_controller_prio.sv - N-line level/edge interrupt controller with nesting FSM
module interrupt_controller_prio
  import irq_ctrl_pkg::*;
#(
  parameter int                 IRQ_NUM     = 16,
  parameter logic [IRQ_NUM-1:0] EDGE_MASK   = '0,
  parameter bit                 ROUND_ROBIN = 1'b0,
  parameter logic [31:0]        CAUSE_BASE  = CAUSE_BASE_DEFAULT
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               exception_i,
  input  logic [IRQ_NUM-1:0] irq_req_i,
  input  logic [IRQ_NUM-1:0] mie_i,
  input  logic               mret_i,
  output logic               irq_o,
  output logic [31:0]        irq_cause_o,
  output logic [IRQ_NUM-1:0] irq_ret_o,
  output logic [IRQ_NUM-1:0] irq_pending_o
);

  localparam int IW = (IRQ_NUM > 1) ? $clog2(IRQ_NUM) : 1;

  irq_state_t         state_q, state_d;
  logic [IW-1:0]      served_q, rr_ptr_q, winner;
  logic [IRQ_NUM-1:0] served_oh_q, edge_pend_q, prev_q;
  logic [IRQ_NUM-1:0] pending, eligible, grant;
  logic               valid, accept;

  assign pending       = (irq_req_i & ~EDGE_MASK) | (edge_pend_q & EDGE_MASK);
  assign eligible      = pending & mie_i;
  assign irq_pending_o = pending;

  irq_prio_arbiter #(
    .IRQ_NUM (IRQ_NUM),
    .IW      (IW)
  ) u_arbiter (
    .eligible (eligible),
    .rr_ptr   (rr_ptr_q),
    .rr_en    (ROUND_ROBIN),
    .valid    (valid),
    .winner   (winner),
    .grant    (grant)
  );

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    irq_ret_o   = '0;
    irq_cause_o = 32'h0;
    case (state_q)
      IDLE: begin
        if (exception_i && !mret_i) begin
          state_d = EXC;
        end else if (!exception_i && !mret_i && valid) begin
          accept  = 1'b1;
          state_d = IRQ;
        end
      end
      IRQ: begin
        // mret together with an exception is the exception's return, not ours.
        if (exception_i && !mret_i) begin
          state_d = IRQ_EXC;
        end else if (mret_i && !exception_i) begin
          state_d   = IDLE;
          irq_ret_o = served_oh_q;
        end
      end
      EXC:     if (mret_i) state_d = IDLE;
      IRQ_EXC: if (mret_i) state_d = IRQ;
      default: state_d = IDLE;
    endcase
    if (rst_i) begin
      accept    = 1'b0;
      irq_ret_o = '0;
    end
    irq_o = accept;
    if (accept) begin
      irq_cause_o = idx_to_cause(CAUSE_BASE, 32'(winner));
    end else if (state_q == IRQ || state_q == IRQ_EXC) begin
      irq_cause_o = idx_to_cause(CAUSE_BASE, 32'(served_q));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      served_q    <= '0;
      served_oh_q <= '0;
      edge_pend_q <= '0;
      prev_q      <= '0;
      rr_ptr_q    <= IW'(IRQ_NUM - 1);
    end else begin
      state_q     <= state_d;
      prev_q      <= irq_req_i;
      // A fresh edge outranks the acknowledge clearing the same line.
      edge_pend_q <= ((edge_pend_q & ~irq_ret_o) | (irq_req_i & ~prev_q)) & EDGE_MASK;
      if (accept) begin
        served_q    <= winner;
        served_oh_q <= grant;
        rr_ptr_q    <= winner;
      end
    end
  end

endmodule

// File: tb/tb_interrupt_controller_prio.sv
// tb/tb_interrupt_controller_prio.sv - fixed and round-robin controllers against a behavioural model
module tb_interrupt_controller_prio;

  localparam int          N  = 16;
  localparam logic [N-1:0] EM = 16'h0030;
  localparam logic [31:0] CB = 32'h8000_0010;

  logic         clk_i = 1'b0;
  logic         rst_i, exception_i, mret_i;
  logic [N-1:0] irq_req_i, mie_i;
  logic         irq_fix, irq_rr;
  logic [31:0]  cause_fix, cause_rr;
  logic [N-1:0] ret_fix, ret_rr, pend_fix, pend_rr;

  always #5 clk_i = ~clk_i;

  interrupt_controller_prio #(.IRQ_NUM(N), .EDGE_MASK(EM), .ROUND_ROBIN(1'b0), .CAUSE_BASE(CB)) dut_fix (
    .clk_i(clk_i), .rst_i(rst_i), .exception_i(exception_i), .irq_req_i(irq_req_i),
    .mie_i(mie_i), .mret_i(mret_i), .irq_o(irq_fix), .irq_cause_o(cause_fix),
    .irq_ret_o(ret_fix), .irq_pending_o(pend_fix));

  interrupt_controller_prio #(.IRQ_NUM(N), .EDGE_MASK(EM), .ROUND_ROBIN(1'b1), .CAUSE_BASE(CB)) dut_rr (
    .clk_i(clk_i), .rst_i(rst_i), .exception_i(exception_i), .irq_req_i(irq_req_i),
    .mie_i(mie_i), .mret_i(mret_i), .irq_o(irq_rr), .irq_cause_o(cause_rr),
    .irq_ret_o(ret_rr), .irq_pending_o(pend_rr));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Model: index 0 is the fixed-priority instance, 1 the round-robin one.
  bit           m_in_irq[2], m_in_exc[2];
  int           m_served[2], m_ptr[2];
  logic [N-1:0] m_epend[2], m_prev[2];
  bit           e_irq[2];
  int           e_win[2];
  logic [N-1:0] e_ret[2], e_pend[2];
  logic [31:0]  e_cause[2];

  function automatic int pick(input logic [N-1:0] elig, input int start);
    for (int k = 0; k < N; k++) begin
      if (elig[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  task automatic model_comb();
    logic [N-1:0] elig;
    for (int m = 0; m < 2; m++) begin
      e_pend[m] = (irq_req_i & ~EM) | (m_epend[m] & EM);
      elig      = e_pend[m] & mie_i;
      e_win[m]  = pick(elig, (m == 1) ? (m_ptr[m] + 1) % N : 0);
      e_irq[m]  = !rst_i && !m_in_irq[m] && !m_in_exc[m] && !exception_i && !mret_i && (e_win[m] >= 0);
      e_ret[m]  = (!rst_i && m_in_irq[m] && !m_in_exc[m] && mret_i && !exception_i)
                  ? (N'(1) << m_served[m]) : '0;
      e_cause[m] = e_irq[m] ? CB + 32'(e_win[m]) : (m_in_irq[m] ? CB + 32'(m_served[m]) : 32'h0);
    end
  endtask

  task automatic model_seq();
    for (int m = 0; m < 2; m++) begin
      if (rst_i) begin
        m_in_irq[m] = 1'b0; m_in_exc[m] = 1'b0; m_served[m] = 0; m_ptr[m] = N - 1;
        m_epend[m]  = '0;   m_prev[m]   = '0;
      end else begin
        m_epend[m] = (m_epend[m] & ~e_ret[m]) | (irq_req_i & ~m_prev[m] & EM);
        m_prev[m]  = irq_req_i;
        if (!m_in_irq[m] && !m_in_exc[m]) begin
          if (exception_i && !mret_i) m_in_exc[m] = 1'b1;
          else if (e_irq[m]) begin
            m_in_irq[m] = 1'b1; m_served[m] = e_win[m]; m_ptr[m] = e_win[m];
          end
        end else if (!m_in_exc[m]) begin
          if (exception_i && !mret_i) m_in_exc[m] = 1'b1;
          else if (mret_i && !exception_i) m_in_irq[m] = 1'b0;
        end else if (mret_i) begin
          m_in_exc[m] = 1'b0;
        end
      end
    end
  endtask

  task automatic settle();
    #2;
    model_comb();
    check("irq_fix", irq_fix, e_irq[0]);     check("cause_fix", cause_fix, e_cause[0]);
    check("ret_fix", ret_fix, e_ret[0]);     check("pend_fix", pend_fix, e_pend[0]);
    check("irq_rr", irq_rr, e_irq[1]);       check("cause_rr", cause_rr, e_cause[1]);
    check("ret_rr", ret_rr, e_ret[1]);       check("pend_rr", pend_rr, e_pend[1]);
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_seq();
    @(negedge clk_i);
  endtask

  initial begin
    rst_i = 1'b1; exception_i = 1'b0; mret_i = 1'b0; irq_req_i = '0; mie_i = '0;
    @(negedge clk_i);
    tick(); tick();
    rst_i = 1'b0; settle();
    check("rst_irq", irq_fix, 0); check("rst_cause", cause_fix, 0);
    check("rst_ret", ret_fix, 0); check("rst_pend", pend_fix, 0);

    // fixed priority: 3 before 7
    irq_req_i = 16'h0088; mie_i = 16'hFFFF; settle();
    check("fix_irq3", irq_fix, 1); check("fix_cause3", cause_fix, 32'h8000_0013); tick();
    settle(); check("fix_busy", irq_fix, 0); tick();
    mret_i = 1'b1; irq_req_i = 16'h0080; settle(); check("fix_ret3", ret_fix, 16'h0008); tick();
    mret_i = 1'b0; settle(); check("fix_cause7", cause_fix, 32'h8000_0017); tick();
    mret_i = 1'b1; irq_req_i = '0; settle(); tick(); mret_i = 1'b0;

    // round robin over lines 0..2, wrapping back to 0
    irq_req_i = 16'h0007;
    for (int k = 0; k < 4; k++) begin
      settle(); check("rr_irq", irq_rr, 1); check("rr_cause", cause_rr, CB + 32'(k % 3)); tick();
      mret_i = 1'b1; settle(); check("rr_ret", ret_rr, 16'(1 << (k % 3))); tick(); mret_i = 1'b0;
    end
    irq_req_i = '0; settle(); tick();

    // edge line 5 captured while masked
    mie_i = 16'hFFDF; irq_req_i = 16'h0020; settle(); check("edge_noirq", irq_fix, 0); tick();
    irq_req_i = '0; settle(); check("edge_pend", pend_fix[5], 1); check("edge_noirq2", irq_fix, 0); tick();
    mie_i = 16'hFFFF; settle(); check("edge_irq", irq_fix, 1); check("edge_cause", cause_fix, 32'h8000_0015); tick();
    mret_i = 1'b1; settle(); check("edge_ret", ret_fix, 16'h0020); tick(); mret_i = 1'b0;
    settle(); check("edge_clr", pend_fix[5], 0); tick();

    // nesting an exception inside service of line 2
    irq_req_i = 16'h0004; settle(); check("nest_cause", cause_fix, 32'h8000_0012); tick();
    exception_i = 1'b1; settle(); check("nest_exc_irq", irq_fix, 0); tick(); exception_i = 1'b0;
    mret_i = 1'b1; settle(); check("nest_ret1", ret_fix, 0); tick();
    irq_req_i = '0; settle(); check("nest_ret2", ret_fix, 16'h0004); tick(); mret_i = 1'b0;

    // simultaneous exception and mret while serving
    irq_req_i = 16'h0004; settle(); tick(); irq_req_i = '0;
    exception_i = 1'b1; mret_i = 1'b1; settle();
    check("sim_ret", ret_fix, 0); check("sim_irq", irq_fix, 0); tick();
    exception_i = 1'b0; mret_i = 1'b0; settle(); check("sim_still", cause_fix, 32'h8000_0012); tick();
    mret_i = 1'b1; settle(); check("sim_ret_end", ret_fix, 16'h0004); tick(); mret_i = 1'b0;

    // reset in the middle of nested service of edge line 4
    irq_req_i = 16'h0010; settle(); tick();
    irq_req_i = '0; settle(); check("rst_acc4", cause_fix, 32'h8000_0014); tick();
    exception_i = 1'b1; settle(); tick(); exception_i = 1'b0;
    settle(); check("rst_pend4", pend_fix[4], 1); tick();
    rst_i = 1'b1; irq_req_i = 16'h0002; settle();
    check("rst_force_irq", irq_fix, 0); check("rst_force_ret", ret_fix, 0); tick();
    rst_i = 1'b0; settle();
    check("rst_pend_clr", pend_fix[4], 0); check("post_rst_irq", irq_fix, 1);
    check("post_rst_cause", cause_fix, 32'h8000_0011); tick();
    mret_i = 1'b1; irq_req_i = '0; settle(); tick(); mret_i = 1'b0;

    // random traffic
    for (int c = 0; c < 400; c++) begin
      rst_i       = ($urandom_range(0, 99) == 0);
      exception_i = ($urandom_range(0, 7) == 0);
      mret_i      = ($urandom_range(0, 3) == 0);
      irq_req_i   = N'($urandom) & N'($urandom);
      mie_i       = N'($urandom) | N'($urandom);
      settle();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
